// File: rtl/bitmask_enc_pkg.sv
// Shared types and helpers for the bitmask index encoder.
// Build option: BITMASK_ENC_MSB_FIRST_EN selects highest-set-bit-first scan order.
package bitmask_enc_pkg;

    localparam int DEFAULT_N    = 8;
    localparam int POPCNT_MAX_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // True when exactly one bit of v is set; callers zero-extend narrower masks.
    function automatic logic popcount_is_one(input logic [POPCNT_MAX_W-1:0] v);
        return (v != {POPCNT_MAX_W{1'b0}}) &&
               ((v & (v - {{(POPCNT_MAX_W-1){1'b0}}, 1'b1})) == {POPCNT_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/bitmask_index_encoder_find_first_set.sv
// Combinational priority finder: index of the lowest (or highest) set bit of a mask.
// Scan direction is a parameter so the top can tie it to BITMASK_ENC_MSB_FIRST_EN.
module find_first_set
    import bitmask_enc_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int W         = $clog2(N),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [N-1:0] mask_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Later loop iterations take priority, so the loop runs toward the winning end.
    always_comb begin
        idx_o   = {W{1'b0}};
        found_o = |mask_i;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                idx_o = mask_i[i] ? W'(i) : idx_o;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                idx_o = mask_i[i] ? W'(i) : idx_o;
            end
        end
    end

endmodule

// File: rtl/bitmask_index_encoder.sv
// Sequential mask-to-index encoder: emits one set-bit index per output handshake.
// Build option: BITMASK_ENC_MSB_FIRST_EN scans highest set bit first (default lowest first).
module bitmask_index_encoder
    import bitmask_enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_mask,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last
);

`ifdef BITMASK_ENC_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic           out_last_q, out_last_d;
    logic           in_ready_q, in_ready_d;
    logic [W-1:0]   ffs_idx_s;
    logic           ffs_found_s;

    // The finder looks at next-state pend so the registered index lines up with pend_q.
    find_first_set #(
        .N         (N),
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ffs (
        .mask_i  (pend_d),
        .idx_o   (ffs_idx_s),
        .found_o (ffs_found_s)
    );

    // Next-state logic for the FSM and pending mask; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (flush) begin
            state_d = ST_IDLE;
            pend_d  = {N{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q && (in_mask != {N{1'b0}})) begin
                        pend_d  = in_mask;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (out_valid_q && out_ready) begin
                        pend_d  = pend_q & ~(ONE_N << out_idx_q);
                        state_d = out_last_q ? ST_IDLE : ST_BUSY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pend_d  = {N{1'b0}};
                end
            endcase
        end
    end

    // Output next values; pend_d is non-zero exactly when the FSM is heading to BUSY.
    always_comb begin
        out_valid_d = ffs_found_s;
        out_idx_d   = ffs_idx_s;
        out_last_d  = popcount_is_one(POPCNT_MAX_W'(pend_d));
        in_ready_d  = ~ffs_found_s;
    end

    // State, pending mask and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= {N{1'b0}};
            out_valid_q <= 1'b0;
            out_idx_q   <= {W{1'b0}};
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bitmask_index_encoder.sv
// Scoreboard bench for bitmask_index_encoder: directed cases plus randomized traffic.
module tb_bitmask_index_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_mask;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;

    int errors = 0;
    int checks = 0;
    int exp_idx[$];
    bit exp_last[$];
    int just_pushed = 0;
    bit mon_en = 1'b0;

    bit         prev_accept_nz, prev_flush, prev_stall, prev_last;
    logic [W-1:0] prev_idx;

    always #5 clk = ~clk;

    bitmask_index_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the set bits in scan order; the final one carries last.
    task automatic model_push(input logic [N-1:0] m);
        int order[$];
        for (int pos = 0; pos < N; pos++) begin
`ifdef BITMASK_ENC_MSB_FIRST_EN
            if (m[N-1-pos]) order.push_back(N - 1 - pos);
`else
            if (m[pos]) order.push_back(pos);
`endif
        end
        foreach (order[k]) begin
            exp_idx.push_back(order[k]);
            exp_last.push_back(k == order.size() - 1);
        end
        just_pushed = order.size();
    endtask

    task automatic step(input logic v, input logic [N-1:0] m, input logic f, input logic r);
        @(posedge clk);
        #1;
        in_valid    = v;
        in_mask     = m;
        flush       = f;
        out_ready   = r;
        just_pushed = 0;
        if (v && in_ready && !f && rst_n) model_push(m);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (exp_idx.size() == 0 && in_ready === 1'b1) done = 1'b1;
        end
        if (!done) check("drain_timeout", exp_idx.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_idx"},   out_idx,   0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_in_ready"},  in_ready,  1);
    endtask

    // Monitor: compares presented indices against the queue and tracks handshake rules.
    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            exp_idx.delete();
            exp_last.delete();
            prev_accept_nz = 1'b0;
            prev_flush     = 1'b0;
            prev_stall     = 1'b0;
        end else begin
            if (prev_accept_nz) check("first_latency", out_valid, 1);
            if (prev_flush) check("flush_valid", out_valid, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_idx, prev_idx);
                check("stall_last", out_last, prev_last);
            end
            check("no_bypass", out_valid & in_ready, 0);
            check("in_ready", in_ready, exp_idx.size() == just_pushed);
            if (out_valid) begin
                if (exp_idx.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    check("idx", out_idx, exp_idx[0]);
                    check("last", out_last, exp_last[0]);
                    if (out_ready) begin
                        void'(exp_idx.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
            end
            if (flush) begin
                exp_idx.delete();
                exp_last.delete();
            end
            prev_accept_nz = in_valid && in_ready && !flush && (in_mask != 8'h00);
            prev_flush     = flush;
            prev_stall     = out_valid && !out_ready && !flush;
            prev_idx       = out_idx;
            prev_last      = out_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Lowest-first drain with out_ready held high.
        step(1'b1, 8'b1010_0110, 1'b0, 1'b1);
        wait_idle(20);

        // Empty mask is swallowed without output.
        step(1'b1, 8'b0000_0000, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("zero_mask_valid", out_valid, 0);
        check("zero_mask_ready", in_ready, 1);

        // Stalls hold the presented index.
        step(1'b1, 8'b1000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, i[0]);
        wait_idle(20);

        // Flush during the third index, then a fresh single-bit mask.
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h10, 1'b0, 1'b1);
        wait_idle(20);

        // Mask whose order differs between scan directions.
        step(1'b1, 8'b0101_0001, 1'b0, 1'b1);
        wait_idle(20);

        // Flush coinciding with an offered mask drops the mask.
        step(1'b1, 8'h3C, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("flush_drops_mask", out_valid, 0);

        // Reset in the middle of a drain.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("mid_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end
        wait_idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
